// File: rtl/cla_clk_pkg.sv
// cla_clk_pkg: shared width constants for the registered carry-lookahead adder.
package cla_clk_pkg;
   localparam int WIDTH = 32;
   localparam int GROUP = 4;
endpackage

// File: rtl/cla_clk_cla32.sv
// cla32: combinational carry-lookahead adder built from 4-bit lookahead groups.
// Group carry-outs chain from group to group; carries within a group are fully flattened.
module cla32
   import cla_clk_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_ci,
   output logic [WIDTH-1:0] o_s,
   output logic             o_co
);
   logic [WIDTH-1:0] w_g, w_p;
   logic [GROUP-1:0] w_gg, w_pp, w_cc;
   logic             w_c;
   always_comb begin
      w_g  = i_a & i_b;
      w_p  = i_a ^ i_b;
      w_c  = i_ci;
      w_gg = '0;
      w_pp = '0;
      w_cc = '0;
      o_s  = '0;
      for (int n = 0; n < WIDTH / GROUP; n++) begin
         w_gg = w_g[n*GROUP +: GROUP];
         w_pp = w_p[n*GROUP +: GROUP];
         w_cc[0] = w_c;
         w_cc[1] = w_gg[0] | (w_pp[0] & w_c);
         w_cc[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c);
         w_cc[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                 | (w_pp[2] & w_pp[1] & w_pp[0] & w_c);
         o_s[n*GROUP +: GROUP] = w_pp ^ w_cc;
         w_c = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
             | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]) | (&w_pp & w_c);
      end
      o_co = w_c;
   end
endmodule

// File: rtl/cla_clk.sv
// cla_clk: 32-bit CLA adder with registered operands and registered sum/carry-out.
// Latency is two rising edges from input sample to output; one add per cycle.
module cla_clk
   import cla_clk_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s_cla,
   output logic             co_cla
);
   logic [WIDTH-1:0] r_a, r_b, w_s;
   logic             r_ci, w_co;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_ci   <= 1'b0;
         s_cla  <= '0;
         co_cla <= 1'b0;
      end else begin
         r_a    <= a;
         r_b    <= b;
         r_ci   <= ci;
         s_cla  <= w_s;
         co_cla <= w_co;
      end
   end
   cla32 u_cla32 (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_ci (r_ci),
      .o_s  (w_s),
      .o_co (w_co)
   );
endmodule

// File: tb/tb_cla_clk.sv
// tb_cla_clk: directed and random checks of cla_clk against a 33-bit arithmetic model.
module tb_cla_clk;
   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] a = 32'h0, b = 32'h0;
   logic        ci = 1'b0;
   logic [31:0] s_cla;
   logic        co_cla;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];
   string       tag_q[$];

   cla_clk dut (
      .clock   (clock),
      .reset_n (reset_n),
      .a       (a),
      .b       (b),
      .ci      (ci),
      .s_cla   (s_cla),
      .co_cla  (co_cla)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
      n_cmp++;
      assert (got === want)
      else begin
         n_err++;
         $error("FAIL %s: got co=%0b s=%h expected co=%0b s=%h", tag, got[32], got[31:0], want[32], want[31:0]);
      end
   endtask

   // Drive one vector, clock it in, and check whatever result is due two edges after its capture.
   task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic vci, input string tag);
      a  = va;
      b  = vb;
      ci = vci;
      exp_q.push_back({1'b0, va} + {1'b0, vb} + {32'b0, vci});
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
      if (exp_q.size() >= 2) begin
         check(tag_q.pop_front(), {co_cla, s_cla}, exp_q.pop_front());
      end
      @(negedge clock);
   endtask

   initial begin
      a  = 32'hDEAD_BEEF;
      b  = 32'h1234_5678;
      ci = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset", {co_cla, s_cla}, 33'h0);
      @(posedge clock);
      #1;
      check("reset_hold", {co_cla, s_cla}, 33'h0);
      @(negedge clock);
      reset_n = 1'b1;
      apply(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
      check("post_reset_flush", {co_cla, s_cla}, 33'h0);
      apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "wrap_ripple");
      apply(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, "all_propagate");
      apply(32'h135F_A562, 32'h3561_4642, 1'b0, "directed_mix");
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max");
      apply(32'h8000_0000, 32'h8000_0000, 1'b0, "msb_carry");
      apply(32'h0000_000F, 32'h0000_0001, 1'b0, "group_carry");
      for (int i = 0; i < 1000; i++) begin
         apply($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
      end
      apply(32'h0, 32'h0, 1'b0, "drain");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
